// File: rtl/conv_pkg.sv
// Shared state encoding, tap/parameter counts and output-geometry helper
// for the layer-level convolution controller.
package conv_pkg;

   localparam int NUM_TAPS   = 9;
   localparam int NUM_PARAMS = 18;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STREAM,
      DRAIN,
      DONE
   } conv_ctrl_state;

   // Output side length of a valid (unpadded) convolution; win is 1 or 3.
   function automatic logic [7:0] out_side(
      input logic [7:0] dim,
      input logic [1:0] win,
      input logic       stride
   );
      logic [7:0] span;
      span     = dim - {6'd0, win};
      out_side = (stride ? (span >> 1) : span) + 8'd1;
   endfunction

endpackage

// File: rtl/conv_param_bank.sv
// Serial-load register bank: the first NUM_TAPS bytes fill the weight bank,
// the next NUM_TAPS bytes fill the bias bank.
module conv_param_bank
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int N_BYTES    = NUM_PARAMS
)
(
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 i_clear,
   input  logic                                 i_wr_en,
   input  logic [DATA_WIDTH-1:0]                i_data,
   output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  o_weights,
   output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  o_biases,
   output logic                                 o_load_done
);

   logic [4:0]                          r_idx;
   logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] r_weights;
   logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] r_biases;

   // Asserted during the write that completes the parameter set.
   assign o_load_done = i_wr_en && (r_idx == 5'(N_BYTES - 1));

   always_ff @(posedge clock) begin
      // NOTE: the banks are small register files, not RAM, so they take the
      // reset like any other state and read back as zero until loaded.
      if (reset) begin
         r_idx     <= '0;
         r_weights <= '0;
         r_biases  <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_wr_en) begin
         if (r_idx < 5'(NUM_TAPS)) begin
            r_weights[r_idx[3:0]] <= i_data;
         end else begin
            r_biases[4'(r_idx - 5'(NUM_TAPS))] <= i_data;
         end
         r_idx <= o_load_done ? 5'd0 : r_idx + 5'd1;
      end
   end

   assign o_weights = r_weights;
   assign o_biases  = r_biases;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Sequences one conv engine over every channel of a layer: parameter load,
// pixel streaming and result drain per channel, then a one-cycle done pulse.
module conv_layer_ctrl
   import conv_pkg::conv_ctrl_state, conv_pkg::IDLE, conv_pkg::LOAD,
          conv_pkg::STREAM, conv_pkg::DRAIN, conv_pkg::DONE,
          conv_pkg::NUM_TAPS, conv_pkg::out_side;
#(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PARAMS = 18,
   parameter int CH_WIDTH   = 8
)
(
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [7:0]                           cfg_input_dim,
   input  logic [1:0]                           cfg_window_dim,
   input  logic                                 cfg_stride,
   input  logic [CH_WIDTH-1:0]                  cfg_num_channels,
   input  logic [DATA_WIDTH-1:0]                param_data,
   input  logic                                 param_valid,
   output logic                                 param_ready,
   input  logic [DATA_WIDTH-1:0]                pix_data,
   input  logic                                 pix_empty,
   output logic                                 pix_rd_en,
   output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  conv_weights,
   output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]  conv_biases,
   output logic                                 conv_stride,
   output logic [7:0]                           conv_input_dim,
   output logic [1:0]                           conv_window_dim,
   output logic [DATA_WIDTH-1:0]                conv_new_pixel,
   output logic                                 conv_new_data_valid,
   input  logic                                 conv_idle,
   input  logic [31:0]                          conv_result,
   input  logic                                 conv_result_valid,
   output logic                                 conv_out_accepting,
   output logic [31:0]                          out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [CH_WIDTH-1:0]                  out_channel,
   output logic                                 busy,
   output logic                                 done
);

   conv_ctrl_state      r_state;
   logic [7:0]          r_input_dim;
   logic [1:0]          r_window_dim;
   logic                r_stride;
   logic [CH_WIDTH-1:0] r_num_channels;
   logic [CH_WIDTH-1:0] r_channel;
   logic [15:0]         r_exp_pixels;
   logic [15:0]         r_exp_results;
   logic [15:0]         r_pix_cnt;
   logic [15:0]         r_res_cnt;
   logic                r_param_ready;
   logic                r_counting;
   logic                r_busy;
   logic                r_done;

   logic [1:0]          w_win;
   logic [7:0]          w_side;
   logic                w_accept_start;
   logic                w_param_xfer;
   logic                w_load_done;
   logic                w_pop;
   logic [15:0]         w_res_next;
   logic                w_drained;
   logic                w_last_channel;

   assign w_win          = (cfg_window_dim == 2'd3) ? 2'd3 : 2'd1;
   assign w_side         = out_side(cfg_input_dim, w_win, cfg_stride);
   assign w_accept_start = (r_state == IDLE) && start;
   assign w_param_xfer   = param_valid && r_param_ready;

   // NOTE: the pop is a continuous assign so the FIFO and engine see it in the
   // same cycle as their own handshake inputs; no latch, no extra cycle.
   assign w_pop = (r_state == STREAM) && !pix_empty && conv_idle &&
                  (r_pix_cnt < r_exp_pixels);

   // Completion must see a result arriving in the same cycle as the check.
   assign w_res_next     = r_res_cnt + (conv_result_valid ? 16'd1 : 16'd0);
   assign w_drained      = (w_res_next == r_exp_results);
   assign w_last_channel = (r_channel == r_num_channels - CH_WIDTH'(1));

   conv_param_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_BYTES    (NUM_PARAMS)
   ) u_param_bank (
      .clock       (clock),
      .reset       (reset),
      .i_clear     (w_accept_start),
      .i_wr_en     (w_param_xfer),
      .i_data      (param_data),
      .o_weights   (conv_weights),
      .o_biases    (conv_biases),
      .o_load_done (w_load_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= IDLE;
         r_input_dim    <= '0;
         r_window_dim   <= '0;
         r_stride       <= 1'b0;
         r_num_channels <= '0;
         r_channel      <= '0;
         r_exp_pixels   <= '0;
         r_exp_results  <= '0;
         r_pix_cnt      <= '0;
         r_res_cnt      <= '0;
         r_param_ready  <= 1'b0;
         r_counting     <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_pop) begin
            r_pix_cnt <= r_pix_cnt + 16'd1;
         end
         if (r_counting && conv_result_valid) begin
            r_res_cnt <= w_res_next;
         end

         case (r_state)
            IDLE: begin
               if (start) begin
                  r_input_dim    <= cfg_input_dim;
                  r_window_dim   <= cfg_window_dim;
                  r_stride       <= cfg_stride;
                  r_num_channels <= cfg_num_channels;
                  r_exp_pixels   <= 16'(cfg_input_dim) * 16'(cfg_input_dim);
                  r_exp_results  <= 16'(w_side) * 16'(w_side);
                  if (cfg_num_channels == '0) begin
                     r_state <= DONE;
                     r_busy  <= 1'b1;
                     r_done  <= 1'b1;
                  end else if (cfg_input_dim >= {6'd0, w_win}) begin
                     r_state       <= LOAD;
                     r_channel     <= '0;
                     r_busy        <= 1'b1;
                     r_param_ready <= 1'b1;
                  end
               end
            end

            LOAD: begin
               if (w_load_done) begin
                  r_state       <= STREAM;
                  r_param_ready <= 1'b0;
                  r_counting    <= 1'b1;
                  r_pix_cnt     <= '0;
                  r_res_cnt     <= '0;
               end
            end

            STREAM: begin
               if (w_pop && (r_pix_cnt + 16'd1 == r_exp_pixels)) begin
                  r_state <= DRAIN;
               end
            end

            DRAIN: begin
               if (w_drained) begin
                  r_counting <= 1'b0;
                  if (w_last_channel) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state       <= LOAD;
                     r_channel     <= r_channel + CH_WIDTH'(1);
                     r_param_ready <= 1'b1;
                  end
               end
            end

            DONE: begin
               r_state   <= IDLE;
               r_busy    <= 1'b0;
               r_channel <= '0;
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign param_ready         = r_param_ready;
   assign pix_rd_en           = w_pop;
   assign conv_new_data_valid = w_pop;
   assign conv_new_pixel      = pix_data;
   assign conv_stride         = r_stride;
   assign conv_input_dim      = r_input_dim;
   assign conv_window_dim     = r_window_dim;
   assign conv_out_accepting  = r_counting && out_ready;
   assign out_data            = conv_result;
   assign out_valid           = conv_result_valid;
   assign out_channel         = r_channel;
   assign busy                = r_busy;
   assign done                = r_done;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl with a small engine/FIFO/parameter model.
module tb_conv_layer_ctrl;

   logic              clock;
   logic              reset;
   logic              start;
   logic [7:0]        cfg_input_dim;
   logic [1:0]        cfg_window_dim;
   logic              cfg_stride;
   logic [7:0]        cfg_num_channels;
   logic [7:0]        param_data;
   logic              param_valid;
   logic              param_ready;
   logic [7:0]        pix_data;
   logic              pix_empty;
   logic              pix_rd_en;
   logic [8:0][7:0]   conv_weights;
   logic [8:0][7:0]   conv_biases;
   logic              conv_stride;
   logic [7:0]        conv_input_dim;
   logic [1:0]        conv_window_dim;
   logic [7:0]        conv_new_pixel;
   logic              conv_new_data_valid;
   logic              conv_idle;
   logic [31:0]       conv_result;
   logic              conv_result_valid;
   logic              conv_out_accepting;
   logic [31:0]       out_data;
   logic              out_valid;
   logic              out_ready;
   logic [7:0]        out_channel;
   logic              busy;
   logic              done;

   int n_vec = 0;
   int n_bad = 0;

   // model state and monitors
   int cyc = 0;
   bit eng_on = 0;
   bit pop_pend = 0, par_pend = 0, emit = 0;
   int exp_pix = 1, exp_res = 1;
   int pops, chan_pops, par_cnt, par_base, fifo_val, res_gen;
   int empty_mode, idle_mode, rdy_lo_start;
   int res_tot, res_ch0, res_ch1, done_cnt, done_cyc, last_res_cyc, busy_cnt;
   int viol_pop, viol_acc, viol_pr, acc_seen, pix_err, start_cyc;
   logic busy_after;

   conv_layer_ctrl #(.DATA_WIDTH(8), .NUM_PARAMS(18), .CH_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .start(start),
      .cfg_input_dim(cfg_input_dim), .cfg_window_dim(cfg_window_dim),
      .cfg_stride(cfg_stride), .cfg_num_channels(cfg_num_channels),
      .param_data(param_data), .param_valid(param_valid), .param_ready(param_ready),
      .pix_data(pix_data), .pix_empty(pix_empty), .pix_rd_en(pix_rd_en),
      .conv_weights(conv_weights), .conv_biases(conv_biases),
      .conv_stride(conv_stride), .conv_input_dim(conv_input_dim),
      .conv_window_dim(conv_window_dim), .conv_new_pixel(conv_new_pixel),
      .conv_new_data_valid(conv_new_data_valid), .conv_idle(conv_idle),
      .conv_result(conv_result), .conv_result_valid(conv_result_valid),
      .conv_out_accepting(conv_out_accepting), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_channel(out_channel),
      .busy(busy), .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Bytes base+1 .. base+9, byte 0 first.
   function automatic logic [8:0][7:0] ramp(input int base);
      logic [8:0][7:0] v;
      for (int i = 0; i < 9; i++) v[i] = 8'(base + i + 1);
      return v;
   endfunction

   // Engine, FIFO and parameter source: drive at negedge, observe 1 ns later.
   always begin
      @(negedge clock);
      cyc = cyc + 1;
      emit = 1'b0;
      if (pop_pend) begin
         pops++;
         chan_pops++;
         fifo_val++;
         emit = (chan_pops > exp_pix - exp_res);
         if (chan_pops == exp_pix) chan_pops = 0;
      end
      if (par_pend) par_cnt++;
      if (eng_on) begin
         conv_result_valid = emit;
         if (emit) begin
            conv_result = 32'hC0DE_0000 + 32'(res_gen);
            res_gen++;
         end
         pix_empty   = (empty_mode != 0) && (cyc % 2 == 1);
         conv_idle   = !((idle_mode != 0) && (cyc % 3 == 0));
         pix_data    = 8'(fifo_val);
         param_valid = 1'b1;
         param_data  = 8'(par_base + (par_cnt / 18) * 32 + (par_cnt % 18) + 1);
         out_ready   = !(cyc >= rdy_lo_start && cyc < rdy_lo_start + 10);
      end else begin
         conv_result_valid = 1'b0;
         pix_empty   = 1'b1;
         conv_idle   = 1'b0;
         param_valid = 1'b0;
         out_ready   = 1'b0;
      end
      #1;
      pop_pend = pix_rd_en;
      par_pend = param_valid && param_ready;
      if (pix_rd_en && (pix_empty || !conv_idle)) viol_pop++;
      if (conv_new_data_valid !== pix_rd_en) pix_err++;
      if (pix_rd_en && conv_new_pixel !== 8'(fifo_val)) pix_err++;
      if (conv_out_accepting && !out_ready) viol_acc++;
      if (conv_out_accepting) acc_seen++;
      if (param_ready && conv_out_accepting) viol_pr++;
      if (out_valid) begin
         res_tot++;
         last_res_cyc = cyc;
         if (out_channel == 8'd0) res_ch0++;
         else if (out_channel == 8'd1) res_ch1++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (cyc == done_cyc + 1) busy_after = busy;
   end

   task automatic launch(input logic [7:0] dim, input logic [1:0] wd, input logic st,
                         input logic [7:0] nch, input int e_pix, input int e_res,
                         input int pbase, input int emode, input int imode, input int rlo);
      @(negedge clock); #2;
      pops = 0; chan_pops = 0; par_cnt = 0; par_base = pbase; fifo_val = 1; res_gen = 0;
      res_tot = 0; res_ch0 = 0; res_ch1 = 0; done_cnt = 0; done_cyc = -10; last_res_cyc = -10;
      busy_cnt = 0; viol_pop = 0; viol_acc = 0; viol_pr = 0; acc_seen = 0; pix_err = 0;
      busy_after = 1'b1; pop_pend = 1'b0; par_pend = 1'b0;
      exp_pix = e_pix; exp_res = e_res; empty_mode = emode; idle_mode = imode;
      rdy_lo_start = (rlo < 0) ? 1000000 : cyc + rlo;
      eng_on = 1'b1;
      cfg_input_dim = dim; cfg_window_dim = wd; cfg_stride = st; cfg_num_channels = nch;
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clock); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clock); #2;
         if (done_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (3) @(negedge clock);
      #2;
   endtask

   task automatic test_reset();
      @(negedge clock); #2;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
      n_vec++; if (param_ready !== 1'b0 || pix_rd_en !== 1'b0 || conv_out_accepting !== 1'b0) begin n_bad++; $display("FAIL reset_handshakes: got %b%b%b want 000", param_ready, pix_rd_en, conv_out_accepting); end
      n_vec++; if (conv_weights !== '0 || conv_biases !== '0) begin n_bad++; $display("FAIL reset_banks: got %h %h want 0", conv_weights, conv_biases); end
      n_vec++; if (out_channel !== 8'd0 || conv_input_dim !== 8'd0 || conv_window_dim !== 2'd0 || conv_stride !== 1'b0) begin n_bad++; $display("FAIL reset_cfg: got ch %0d dim %0d win %0d st %b want zeros", out_channel, conv_input_dim, conv_window_dim, conv_stride); end
   endtask

   task automatic test_single_channel();
      bit ok;
      launch(8'd5, 2'd3, 1'b0, 8'd1, 25, 9, 0, 0, 0, -1);
      wait_done(400, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL single_timeout: got no done want done"); end
      n_vec++; if (pops !== 25) begin n_bad++; $display("FAIL single_pops: got %0d want 25", pops); end
      n_vec++; if (par_cnt !== 18) begin n_bad++; $display("FAIL single_params: got %0d want 18", par_cnt); end
      n_vec++; if (conv_weights !== ramp(0)) begin n_bad++; $display("FAIL single_weights: got %h want %h", conv_weights, ramp(0)); end
      n_vec++; if (conv_biases !== ramp(9)) begin n_bad++; $display("FAIL single_biases: got %h want %h", conv_biases, ramp(9)); end
      n_vec++; if (res_tot !== 9 || res_ch0 !== 9) begin n_bad++; $display("FAIL single_results: got %0d/%0d want 9/9", res_tot, res_ch0); end
      n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL single_done_width: got %0d want 1", done_cnt); end
      n_vec++; if (done_cyc !== last_res_cyc + 1) begin n_bad++; $display("FAIL single_done_latency: got %0d want %0d", done_cyc, last_res_cyc + 1); end
      n_vec++; if (conv_input_dim !== 8'd5 || conv_window_dim !== 2'd3 || conv_stride !== 1'b0) begin n_bad++; $display("FAIL single_cfg: got %0d %0d %b want 5 3 0", conv_input_dim, conv_window_dim, conv_stride); end
   endtask

   task automatic test_stride2();
      bit ok;
      launch(8'd5, 2'd3, 1'b1, 8'd1, 25, 4, 0, 0, 0, -1);
      wait_done(400, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL stride_timeout: got no done want done"); end
      n_vec++; if (pops !== 25) begin n_bad++; $display("FAIL stride_pops: got %0d want 25", pops); end
      n_vec++; if (res_tot !== 4) begin n_bad++; $display("FAIL stride_results: got %0d want 4", res_tot); end
      n_vec++; if (done_cnt !== 1 || busy_after !== 1'b0) begin n_bad++; $display("FAIL stride_done_busy: got done %0d busy %b want 1 0", done_cnt, busy_after); end
      n_vec++; if (conv_stride !== 1'b1) begin n_bad++; $display("FAIL stride_latched: got %b want 1", conv_stride); end
   endtask

   task automatic test_two_channels();
      bit ok;
      launch(8'd4, 2'd1, 1'b0, 8'd2, 16, 16, 0, 0, 0, -1);
      wait_done(600, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL twoch_timeout: got no done want done"); end
      n_vec++; if (par_cnt !== 36) begin n_bad++; $display("FAIL twoch_params: got %0d want 36", par_cnt); end
      n_vec++; if (res_ch0 !== 16 || res_ch1 !== 16) begin n_bad++; $display("FAIL twoch_results: got %0d/%0d want 16/16", res_ch0, res_ch1); end
      n_vec++; if (pops !== 32) begin n_bad++; $display("FAIL twoch_pops: got %0d want 32", pops); end
      n_vec++; if (viol_pr !== 0) begin n_bad++; $display("FAIL twoch_param_ready_in_stream: got %0d want 0", viol_pr); end
      n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL twoch_done: got %0d want 1", done_cnt); end
      n_vec++; if (conv_weights !== ramp(32) || conv_biases !== ramp(41)) begin n_bad++; $display("FAIL twoch_bank: got %h %h want %h %h", conv_weights, conv_biases, ramp(32), ramp(41)); end
   endtask

   task automatic test_back_pressure();
      bit ok;
      launch(8'd5, 2'd3, 1'b0, 8'd1, 25, 9, 0, 1, 1, 25);
      wait_done(800, ok);
      n_vec++; if (!ok) begin n_bad++; $display("FAIL bp_timeout: got no done want done"); end
      n_vec++; if (viol_pop !== 0) begin n_bad++; $display("FAIL bp_illegal_pop: got %0d want 0", viol_pop); end
      n_vec++; if (pops !== 25 || pix_err !== 0) begin n_bad++; $display("FAIL bp_pixels: got pops %0d err %0d want 25 0", pops, pix_err); end
      n_vec++; if (res_tot !== 9) begin n_bad++; $display("FAIL bp_results: got %0d want 9", res_tot); end
      n_vec++; if (viol_acc !== 0 || acc_seen == 0) begin n_bad++; $display("FAIL bp_accepting: got bad %0d seen %0d want 0 >0", viol_acc, acc_seen); end
      n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_edge_configs();
      bit ok;
      launch(8'd5, 2'd3, 1'b0, 8'd0, 25, 9, 0, 0, 0, -1);
      wait_done(20, ok);
      n_vec++; if (!ok || done_cyc !== start_cyc + 1) begin n_bad++; $display("FAIL zero_ch_done: got cyc %0d want %0d", done_cyc, start_cyc + 1); end
      n_vec++; if (par_cnt !== 0 || pops !== 0 || done_cnt !== 1) begin n_bad++; $display("FAIL zero_ch_activity: got par %0d pops %0d done %0d want 0 0 1", par_cnt, pops, done_cnt); end
      launch(8'd2, 2'd3, 1'b0, 8'd1, 4, 1, 0, 0, 0, -1);
      repeat (8) @(negedge clock);
      #2;
      n_vec++; if (busy_cnt !== 0 || done_cnt !== 0 || par_cnt !== 0) begin n_bad++; $display("FAIL reject_small_dim: got busy %0d done %0d par %0d want 0 0 0", busy_cnt, done_cnt, par_cnt); end
   endtask

   task automatic test_reset_mid_stream();
      bit ok;
      bit reached;
      launch(8'd5, 2'd3, 1'b0, 8'd1, 25, 9, 0, 0, 0, -1);
      reached = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock); #2;
         if (pops >= 10) begin
            reached = 1'b1;
            break;
         end
      end
      n_vec++; if (!reached) begin n_bad++; $display("FAIL abort_reach_pops: got %0d want 10", pops); end
      reset = 1'b1; eng_on = 1'b0;
      conv_result_valid = 1'b0; pix_empty = 1'b1; conv_idle = 1'b0;
      param_valid = 1'b0; out_ready = 1'b0;
      @(negedge clock); #2;
      n_vec++; if (busy !== 1'b0 || done !== 1'b0 || out_channel !== 8'd0) begin n_bad++; $display("FAIL abort_state: got busy %b done %b ch %0d want 0 0 0", busy, done, out_channel); end
      n_vec++; if (pix_rd_en !== 1'b0 || conv_new_data_valid !== 1'b0 || param_ready !== 1'b0 || conv_out_accepting !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_outputs: got %b%b%b%b%b want 00000", pix_rd_en, conv_new_data_valid, param_ready, conv_out_accepting, out_valid); end
      n_vec++; if (conv_weights !== '0 || conv_biases !== '0 || conv_input_dim !== 8'd0) begin n_bad++; $display("FAIL abort_banks: got %h %h dim %0d want 0", conv_weights, conv_biases, conv_input_dim); end
      reset = 1'b0;
      launch(8'd5, 2'd3, 1'b0, 8'd1, 25, 9, 100, 0, 0, -1);
      wait_done(400, ok);
      n_vec++; if (!ok || done_cnt !== 1) begin n_bad++; $display("FAIL restart_done: got %0d want 1", done_cnt); end
      n_vec++; if (par_cnt !== 18 || conv_weights !== ramp(100) || conv_biases !== ramp(109)) begin n_bad++; $display("FAIL restart_reload: got par %0d w %h want 18 %h", par_cnt, conv_weights, ramp(100)); end
      n_vec++; if (pops !== 25 || res_tot !== 9) begin n_bad++; $display("FAIL restart_totals: got %0d %0d want 25 9", pops, res_tot); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      cfg_input_dim = '0; cfg_window_dim = '0; cfg_stride = 1'b0; cfg_num_channels = '0;
      param_data = '0; param_valid = 1'b0; pix_data = '0; pix_empty = 1'b1;
      conv_idle = 1'b0; conv_result = '0; conv_result_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      @(negedge clock); #2;
      reset = 1'b0;
      test_single_channel();
      test_stride2();
      test_two_channels();
      test_back_pressure();
      test_edge_configs();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
